// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared alu_op class and alu_ctrl operation encodings.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int C_DATA_W = 32;

    // Main-decoder operation classes; 100-111 fall back to ADD
    localparam logic [2:0] C_OP_ADD    = 3'b000;
    localparam logic [2:0] C_OP_BRANCH = 3'b001;
    localparam logic [2:0] C_OP_RTYPE  = 3'b010;
    localparam logic [2:0] C_OP_ITYPE  = 3'b011;

    localparam logic [3:0] C_CTRL_ADD  = 4'b0000;
    localparam logic [3:0] C_CTRL_SUB  = 4'b0001;
    localparam logic [3:0] C_CTRL_SLL  = 4'b0010;
    localparam logic [3:0] C_CTRL_SLT  = 4'b0011;
    localparam logic [3:0] C_CTRL_SLTU = 4'b0100;
    localparam logic [3:0] C_CTRL_XOR  = 4'b0101;
    localparam logic [3:0] C_CTRL_SRL  = 4'b0110;
    localparam logic [3:0] C_CTRL_SRA  = 4'b0111;
    localparam logic [3:0] C_CTRL_OR   = 4'b1000;
    localparam logic [3:0] C_CTRL_AND  = 4'b1001;
    localparam logic [3:0] C_CTRL_BEQ  = 4'b1010;
    localparam logic [3:0] C_CTRL_BNE  = 4'b1011;
    localparam logic [3:0] C_CTRL_BLT  = 4'b1100;
    localparam logic [3:0] C_CTRL_BGE  = 4'b1101;
    localparam logic [3:0] C_CTRL_BLTU = 4'b1110;
    localparam logic [3:0] C_CTRL_BGEU = 4'b1111;

    // Branch codes occupy 1010..1111
    function automatic logic is_branch_ctrl(input logic [3:0] ctrl);
        return ctrl[3] && (ctrl[2:1] != 2'b00);
    endfunction

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_decode.sv
// ============================================================================
// Module  : alu_decode
// Purpose : Combinational decode of alu_op/funct3/funct7 into alu_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_decode
    import alu_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic [2:0] func3,
    input  logic       func7,
    output logic [3:0] alu_ctrl
);

    logic w_is_rtype;

    assign w_is_rtype = (alu_op == C_OP_RTYPE);

    always_comb begin
        alu_ctrl = C_CTRL_ADD;
        case (alu_op)
            C_OP_BRANCH: begin
                case (func3)
                    3'b001:  alu_ctrl = C_CTRL_BNE;
                    3'b100:  alu_ctrl = C_CTRL_BLT;
                    3'b101:  alu_ctrl = C_CTRL_BGE;
                    3'b110:  alu_ctrl = C_CTRL_BLTU;
                    3'b111:  alu_ctrl = C_CTRL_BGEU;
                    default: alu_ctrl = C_CTRL_BEQ;
                endcase
            end
            C_OP_RTYPE, C_OP_ITYPE: begin
                // funct7 selects SUB only for R-type; SRA/SRL for both
                case (func3)
                    3'b000:  alu_ctrl = (w_is_rtype && func7) ? C_CTRL_SUB : C_CTRL_ADD;
                    3'b001:  alu_ctrl = C_CTRL_SLL;
                    3'b010:  alu_ctrl = C_CTRL_SLT;
                    3'b011:  alu_ctrl = C_CTRL_SLTU;
                    3'b100:  alu_ctrl = C_CTRL_XOR;
                    3'b101:  alu_ctrl = func7 ? C_CTRL_SRA : C_CTRL_SRL;
                    3'b110:  alu_ctrl = C_CTRL_OR;
                    default: alu_ctrl = C_CTRL_AND;
                endcase
            end
            default: alu_ctrl = C_CTRL_ADD;
        endcase
    end

endmodule : alu_decode

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module  : alu_exec_unit
// Purpose : Single-cycle ALU/branch datapath with registered outputs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_exec_unit
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [2:0]          alu_op,
    input  logic [2:0]          func3,
    input  logic                func7,
    input  logic [C_DATA_W-1:0] op_a,
    input  logic [C_DATA_W-1:0] op_b,
    output logic                out_valid,
    output logic [C_DATA_W-1:0] alu_o,
    output logic                br_mark,
    output logic [3:0]          alu_ctrl_o
);

    logic [3:0]          w_ctrl;
    logic [C_DATA_W-1:0] w_diff;
    logic [4:0]          w_shamt;
    logic                w_lt_s;
    logic                w_lt_u;
    logic                w_br_kill;
    logic [C_DATA_W-1:0] w_result;
    logic                w_br;

    logic                r_valid;
    logic [C_DATA_W-1:0] r_alu;
    logic                r_br;
    logic [3:0]          r_ctrl;

    alu_decode u_decode (
        .alu_op   (alu_op),
        .func3    (func3),
        .func7    (func7),
        .alu_ctrl (w_ctrl)
    );

    assign w_diff    = op_a - op_b;
    assign w_shamt   = op_b[4:0];
    assign w_lt_s    = $signed(op_a) < $signed(op_b);
    assign w_lt_u    = op_a < op_b;
    // Reserved branch funct3 values decode as BEQ but must never be taken
    assign w_br_kill = (alu_op == C_OP_BRANCH) && (func3[2:1] == 2'b01);

    always_comb begin
        w_result = w_diff;
        w_br     = 1'b1;
        case (w_ctrl)
            C_CTRL_ADD:  w_result = op_a + op_b;
            C_CTRL_SUB:  w_result = w_diff;
            C_CTRL_SLL:  w_result = op_a << w_shamt;
            C_CTRL_SLT:  w_result = {{(C_DATA_W-1){1'b0}}, w_lt_s};
            C_CTRL_SLTU: w_result = {{(C_DATA_W-1){1'b0}}, w_lt_u};
            C_CTRL_XOR:  w_result = op_a ^ op_b;
            C_CTRL_SRL:  w_result = op_a >> w_shamt;
            C_CTRL_SRA:  w_result = $signed(op_a) >>> w_shamt;
            C_CTRL_OR:   w_result = op_a | op_b;
            C_CTRL_AND:  w_result = op_a & op_b;
            C_CTRL_BEQ:  w_br = (w_diff == '0) && !w_br_kill;
            C_CTRL_BNE:  w_br = (w_diff != '0);
            C_CTRL_BLT:  w_br = w_lt_s;
            C_CTRL_BGE:  w_br = !w_lt_s;
            C_CTRL_BLTU: w_br = w_lt_u;
            C_CTRL_BGEU: w_br = !w_lt_u;
            default: begin
                w_result = w_diff;
                w_br     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_alu   <= '0;
            r_br    <= 1'b0;
            r_ctrl  <= C_CTRL_ADD;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_alu  <= w_result;
                r_br   <= w_br;
                r_ctrl <= w_ctrl;
            end
        end
    end

    assign out_valid  = r_valid;
    assign alu_o      = r_alu;
    assign br_mark    = r_br;
    assign alu_ctrl_o = r_ctrl;

endmodule : alu_exec_unit

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module  : tb_alu_exec_unit
// Purpose : Scoreboard bench for alu_exec_unit with an independent ALU model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

    typedef struct packed {
        logic [31:0] alu;
        logic        br;
        logic [3:0]  ctrl;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  alu_op;
    logic [2:0]  func3;
    logic        func7;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic [31:0] alu_o;
    logic        br_mark;
    logic [3:0]  alu_ctrl_o;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t hold_val;
    logic exp_valid;

    alu_exec_unit u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .alu_op     (alu_op),
        .func3      (func3),
        .func7      (func7),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .alu_o      (alu_o),
        .br_mark    (br_mark),
        .alu_ctrl_o (alu_ctrl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model written per instruction class, not per decoded code
    function automatic exp_t model(input logic [2:0] aop, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [4:0]  sh;
        logic [31:0] fill;
        sh   = b[4:0];
        e.br = 1'b1;
        e.alu = a + b;
        e.ctrl = 4'd0;
        if (aop == 3'b001) begin
            e.alu = a - b;
            case (f3)
                3'b000:  begin e.ctrl = 4'd10; e.br = (a == b); end
                3'b001:  begin e.ctrl = 4'd11; e.br = (a != b); end
                3'b100:  begin e.ctrl = 4'd12; e.br = ($signed(a) < $signed(b)); end
                3'b101:  begin e.ctrl = 4'd13; e.br = ($signed(a) >= $signed(b)); end
                3'b110:  begin e.ctrl = 4'd14; e.br = (a < b); end
                3'b111:  begin e.ctrl = 4'd15; e.br = (a >= b); end
                default: begin e.ctrl = 4'd10; e.br = 1'b0; end
            endcase
        end else if (aop == 3'b010 || aop == 3'b011) begin
            case (f3)
                3'b000: if (f7 && aop == 3'b010) begin e.ctrl = 4'd1; e.alu = a - b; end
                        else begin e.ctrl = 4'd0; e.alu = a + b; end
                3'b001: begin e.ctrl = 4'd2; e.alu = a << sh; end
                3'b010: begin e.ctrl = 4'd3; e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                3'b011: begin e.ctrl = 4'd4; e.alu = (a < b) ? 32'd1 : 32'd0; end
                3'b100: begin e.ctrl = 4'd5; e.alu = a ^ b; end
                3'b101: begin
                    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                    if (f7) begin e.ctrl = 4'd7; e.alu = (a >> sh) | fill; end
                    else    begin e.ctrl = 4'd6; e.alu = a >> sh; end
                end
                3'b110: begin e.ctrl = 4'd8; e.alu = a | b; end
                default: begin e.ctrl = 4'd9; e.alu = a & b; end
            endcase
        end
        return e;
    endfunction

    task automatic drive_exp(input logic [2:0] aop, input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [31:0] b, input exp_t e);
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = aop;
        func3    = f3;
        func7    = f7;
        op_a     = a;
        op_b     = b;
        sb.push_back(e);
    endtask

    task automatic drive_model(input logic [2:0] aop, input logic [2:0] f3, input logic f7,
                               input logic [31:0] a, input logic [31:0] b);
        drive_exp(aop, f3, f7, a, b, model(aop, f3, f7, a, b));
    endtask

    // Idle cycles scramble the data inputs to prove the outputs hold
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            alu_op   = 3'($urandom);
            func3    = 3'($urandom);
            func7    = 1'($urandom);
            op_a     = $urandom;
            op_b     = $urandom;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_valid <= 1'b0;
        else        exp_valid <= in_valid;
    end

    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            hold_val = '0;
        end else begin
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("alu_o", alu_o, e.alu);
                    check("br_mark", 32'(br_mark), 32'(e.br));
                    check("alu_ctrl_o", 32'(alu_ctrl_o), 32'(e.ctrl));
                    hold_val = e;
                end
            end else begin
                check("hold_alu_o", alu_o, hold_val.alu);
                check("hold_br_mark", 32'(br_mark), 32'(hold_val.br));
                check("hold_alu_ctrl_o", 32'(alu_ctrl_o), 32'(hold_val.ctrl));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        alu_op   = 3'd0;
        func3    = 3'd0;
        func7    = 1'b0;
        op_a     = 32'd0;
        op_b     = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_o", alu_o, 32'd0);
        check("rst_br_mark", 32'(br_mark), 32'd0);
        check("rst_alu_ctrl_o", 32'(alu_ctrl_o), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Directed vectors with hand-derived results
        drive_exp(3'b010, 3'b000, 1'b1, 32'd5, 32'd7, '{32'hFFFF_FFFE, 1'b1, 4'b0001});
        drive_exp(3'b011, 3'b101, 1'b1, 32'h8000_0000, 32'd4, '{32'hF800_0000, 1'b1, 4'b0111});
        drive_exp(3'b011, 3'b101, 1'b0, 32'h8000_0000, 32'd4, '{32'h0800_0000, 1'b1, 4'b0110});
        drive_exp(3'b001, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, '{32'hFFFF_FFFE, 1'b1, 4'b1100});
        drive_exp(3'b001, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, '{32'hFFFF_FFFE, 1'b0, 4'b1110});
        drive_exp(3'b001, 3'b000, 1'b0, 32'h1234, 32'h1234, '{32'd0, 1'b1, 4'b1010});
        drive_exp(3'b001, 3'b010, 1'b0, 32'h1234, 32'h1234, '{32'd0, 1'b0, 4'b1010});
        drive_exp(3'b011, 3'b000, 1'b1, 32'd5, 32'd7, '{32'd12, 1'b1, 4'b0000});
        drive_exp(3'b111, 3'b101, 1'b1, 32'hFFFF_FFFF, 32'd2, '{32'd1, 1'b1, 4'b0000});
        drive_exp(3'b010, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, '{32'd1, 1'b1, 4'b0011});
        drive_exp(3'b010, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, '{32'd0, 1'b1, 4'b0100});
        idle(1);

        // Three back-to-back operations then idle: valid 1,1,1,0 with result held
        drive_model(3'b010, 3'b100, 1'b0, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
        drive_model(3'b010, 3'b001, 1'b0, 32'h0000_0003, 32'd31);
        drive_model(3'b001, 3'b101, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF);
        idle(3);

        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive_model(3'($urandom), 3'($urandom), 1'($urandom), a, b);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        // Asynchronous reset between edges while a result is on the outputs
        drive_model(3'b010, 3'b110, 1'b0, 32'h1234_5678, 32'h0F0F_0000);
        @(posedge clk);
        #2;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_alu_o", alu_o, 32'd0);
        check("async_rst_br_mark", 32'(br_mark), 32'd0);
        check("async_rst_ctrl", 32'(alu_ctrl_o), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        drive_model(3'b010, 3'b000, 1'b1, 32'd100, 32'd1);
        idle(3);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_alu_exec_unit

`default_nettype wire
